// File: rtl/swap_pkg.sv
// Shared types and defaults for the swap register-file loader.
package swap_pkg;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_SWAP_CYCLES = 3;
  localparam int unsigned IDX_W           = 2;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    SWAP_REQ  = 2'd1,
    SWAP_WAIT = 2'd2,
    DONE      = 2'd3
  } swap_ld_state_t;

  // R1 is the leftmost bit: idx 0 -> 1000, idx 3 -> 0001.
  function automatic logic [1:4] onehot_rin(input logic [IDX_W-1:0] idx);
    onehot_rin = 4'b1000 >> idx;
  endfunction

endpackage

// File: rtl/swap_loader.sv
// Feeds four bytes into swap's R1..R4, requests the swap, waits for it to
// finish, pulses Done and rearms.
module swap_loader
  import swap_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SWAP_CYCLES = DEF_SWAP_CYCLES
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] InData,
  input  logic              InValid,
  output logic              InReady,
  output logic [DATA_W-1:0] Data,
  output logic              Extern,
  output logic [1:4]        RinExt,
  output logic              w,
  output logic              Busy,
  output logic              Done
);

  swap_ld_state_t    state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [1:4]        rin_nxt;
  logic              ready_nxt, w_nxt, busy_nxt, extern_nxt, done_nxt;

  // Next state plus next value of every registered output.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    data_nxt  = Data;
    rin_nxt   = '0;
    case (state)
      LOAD: begin
        if (InReady && InValid) begin
          data_nxt = InData;
          rin_nxt  = onehot_rin(idx);
          idx_nxt  = idx + IDX_W'(1);
          if (idx == IDX_W'(3)) state_nxt = SWAP_REQ;
        end
      end
      SWAP_REQ: begin
        cnt_nxt   = CNT_W'(SWAP_CYCLES);
        state_nxt = SWAP_WAIT;
      end
      SWAP_WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
    // Ready drops on the edge of the final handshake so no fifth byte slips in.
    ready_nxt  = (state == LOAD) && (state_nxt == LOAD);
    w_nxt      = (state == SWAP_REQ);
    busy_nxt   = (state == SWAP_REQ) || (state == SWAP_WAIT);
    extern_nxt = !busy_nxt;
    done_nxt   = (state == DONE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= LOAD;
      idx     <= '0;
      cnt     <= '0;
      Data    <= '0;
      RinExt  <= '0;
      w       <= 1'b0;
      Extern  <= 1'b1;
      InReady <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      Data    <= data_nxt;
      RinExt  <= rin_nxt;
      w       <= w_nxt;
      Extern  <= extern_nxt;
      InReady <= ready_nxt;
      Busy    <= busy_nxt;
      Done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_swap_loader.sv
// Bench for swap_loader with a behavioural stand-in for the swap register file.
module tb_swap_loader;
  import swap_pkg::*;

  localparam int unsigned W = 8;

  logic         Clock = 1'b0;
  logic         Resetn;
  logic [W-1:0] InData;
  logic         InValid;
  logic         InReady, Extern, w, Busy, Done;
  logic [W-1:0] Data;
  logic [1:4]   RinExt;
  logic         InReady1, Extern1, w1, Busy1, Done1;
  logic [W-1:0] Data1;
  logic [1:4]   RinExt1;

  int ncmp = 0;
  int nfail = 0;

  always #5 Clock = ~Clock;

  swap_loader #(.DATA_W(W), .SWAP_CYCLES(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .InData(InData), .InValid(InValid),
    .InReady(InReady), .Data(Data), .Extern(Extern), .RinExt(RinExt),
    .w(w), .Busy(Busy), .Done(Done)
  );

  swap_loader #(.DATA_W(W), .SWAP_CYCLES(1)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .InData(InData), .InValid(InValid),
    .InReady(InReady1), .Data(Data1), .Extern(Extern1), .RinExt(RinExt1),
    .w(w1), .Busy(Busy1), .Done(Done1)
  );

  // Register file: external loads, then R3<=R2, R2<=R1, R1<=R3 after w.
  logic [W-1:0] rf [1:4];
  int sstep = 0;
  always @(posedge Clock) begin
    if (Extern)
      for (int i = 1; i <= 4; i++)
        if (RinExt[i]) rf[i] <= Data;
    if (w) sstep <= 1;
    else case (sstep)
      1: begin rf[3] <= rf[2]; sstep <= 2; end
      2: begin rf[2] <= rf[1]; sstep <= 3; end
      3: begin rf[1] <= rf[3]; sstep <= 0; end
      default: ;
    endcase
  end

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
    logic         rdy;
    logic [3:0]   rin;
    logic [W-1:0] dat;
    logic         wr;
    logic         ext;
    logic         busy;
    logic         done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [W-1:0] d, logic rdy, logic [3:0] rin,
                              logic [W-1:0] dat, logic wr, logic ext, logic busy, logic done);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.rin = rin; r.dat = dat;
    r.wr = wr; r.ext = ext; r.busy = busy; r.done = done;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      InValid = tbl[i].v;
      InData  = tbl[i].d;
      tick();
      chk($sformatf("vec%0d", i), {InReady, RinExt, Data, w, Extern, Busy, Done},
          {tbl[i].rdy, tbl[i].rin, tbl[i].dat, tbl[i].wr, tbl[i].ext, tbl[i].busy, tbl[i].done});
    end
    InValid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] b);
    InValid = 1'b1;
    InData  = b;
    tick();
  endtask

  int split, nbp, d0, d1, wcnt;

  initial begin
    Resetn = 1'b0; InValid = 1'b0; InData = '0;

    // Back-to-back: CA FE BA BE, then the swap window.
    tbl.push_back(mk(1, 8'hCA, 1, 4'b1000, 8'hCA, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'hFE, 1, 4'b0100, 8'hFE, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'hBA, 1, 4'b0010, 8'hBA, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'hBE, 0, 4'b0001, 8'hBE, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0000, 8'hBE, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 0, 4'b0000, 8'hBE, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0000, 8'hBE, 0, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 4'b0000, 8'hBE, 0, 1, 0, 0));
    split = tbl.size();
    // Gapped: 11 22, five idle cycles, 33 44.
    tbl.push_back(mk(1, 8'h11, 1, 4'b1000, 8'h11, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h22, 1, 4'b0100, 8'h22, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 8'h00, 1, 4'b0000, 8'h22, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h33, 1, 4'b0010, 8'h33, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h44, 0, 4'b0001, 8'h44, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0000, 8'h44, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 0, 4'b0000, 8'h44, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0000, 8'h44, 0, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 4'b0000, 8'h44, 0, 1, 0, 0));

    // Reset held for two cycles.
    tick(); tick();
    chk("rst_outs", {InReady, RinExt, Data, w, Extern, Busy, Done}, {1'b0, 4'b0000, 8'h00, 4'b0100});
    chk("rst_outs1", {InReady1, RinExt1, Data1, w1, Extern1, Busy1, Done1}, {1'b0, 4'b0000, 8'h00, 4'b0100});
    Resetn = 1'b1;
    #1 chk("rdy_before_edge", 32'(InReady), 32'd0);
    tick();
    chk("rdy_after_release", 32'(InReady), 32'd1);

    run_vecs(0, split);
    chk("b2b_r1", 32'(rf[1]), 32'hFE);
    chk("b2b_r2", 32'(rf[2]), 32'hCA);
    chk("b2b_r4", 32'(rf[4]), 32'hBE);

    run_vecs(split, tbl.size());
    chk("gap_r1", 32'(rf[1]), 32'h22);
    chk("gap_r2", 32'(rf[2]), 32'h11);
    chk("gap_r4", 32'(rf[4]), 32'h44);

    // Backpressure: 55 held valid through the swap, accepted on first ready.
    send(8'h61); send(8'h62); send(8'h63); send(8'h64);
    InValid = 1'b1; InData = 8'h55;
    nbp = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (RinExt != 4'b0000) begin nbp = n; break; end
    end
    chk("bp_first_rin_cycle", 32'(nbp), 32'd7);
    chk("bp_rin_data", {RinExt, Data}, {4'b1000, 8'h55});
    InValid = 1'b0;
    tick();
    chk("bp_r1", 32'(rf[1]), 32'h55);

    // Reset mid-load discards the partial set.
    send(8'hAA); send(8'hBB);
    InValid = 1'b0;
    Resetn = 1'b0;
    #1 chk("async_rst", {InReady, RinExt, Data, w, Extern, Busy, Done}, {1'b0, 4'b0000, 8'h00, 4'b0100});
    @(negedge Clock);
    tick();
    Resetn = 1'b1;
    tick();
    chk("rdy_after_midrst", {InReady, InReady1}, 2'b11);
    send(8'h01);
    chk("midrst_first_rin", {RinExt, Data}, {4'b1000, 8'h01});
    send(8'h02);
    chk("midrst_r1", 32'(rf[1]), 32'h01);
    send(8'h03); send(8'h04);
    InValid = 1'b0;
    d0 = -1; d1 = -1; wcnt = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (w) wcnt++;
      if (Done && d0 < 0) d0 = n;
      if (Done1 && d1 < 0) d1 = n;
    end
    chk("midrst_w_pulses", 32'(wcnt), 32'd1);
    chk("done_lat_sc3", 32'(d0), 32'd5);
    chk("done_lat_sc1", 32'(d1), 32'd3);
    chk("final_r1_r2", {rf[1], rf[2]}, {8'h02, 8'h01});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
